// File: rtl/chan_accumulator.sv
// -----------------------------------------------------------------------------
// chan_accumulator
//
// Multi-channel sequenced accumulator. A request {channel, value, op} is taken
// over a valid/ready handshake, held through a fixed IDLE -> WAIT -> ACCUM
// sequence, then added to or subtracted from one of NUM_CH accumulators.
// Each channel has a sticky overflow/underflow flag. A read port and an
// 8-bit LED window expose any selected channel combinationally.
//
// Optional feature (compile-time macro):
//   CHAN_ACC_SATURATE_EN  defined   : overflow clamps to all-ones, underflow
//                                     clamps to zero (ovf is still set).
//                         undefined : results wrap modulo 2^ACC_W.
//
// Ports:
//   CLK       in   1        clock, rising edge
//   RST       in   1        asynchronous active-low reset
//   in_valid  in   1        request valid
//   in_ready  out  1        block can accept a request (IDLE)
//   in_ch     in   CH_W     target channel
//   in_value  in   DATA_W   unsigned operand, zero-extended to ACC_W
//   in_sub    in   1        0 = add, 1 = subtract
//   clear     in   1        synchronous clear of accumulators/flags, aborts op
//   rd_ch     in   CH_W     read-port channel select
//   rd_data   out  ACC_W    accumulator[rd_ch] (0 if rd_ch >= NUM_CH)
//   led_sel   in   CH_W     LED channel select
//   led       out  8        accumulator[led_sel][LED_LSB+7:LED_LSB]
//   ovf       out  NUM_CH   sticky per-channel overflow/underflow flags
//   err_ch    out  1        one-cycle pulse: sequenced request had bad channel
//   busy      out  1        FSM not in IDLE
// -----------------------------------------------------------------------------
module chan_accumulator #(
    parameter int   DATA_W   = 32,
    parameter int   ACC_W    = 32,
    parameter int   NUM_CH   = 4,
    parameter int   WAIT_CYC = 1,
    parameter int   LED_LSB  = 16,
    localparam int  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_sub,
    input  logic              clear,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [ACC_W-1:0]  rd_data,
    input  logic [CH_W-1:0]   led_sel,
    output logic [7:0]        led,
    output logic [NUM_CH-1:0] ovf,
    output logic              err_ch,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;

    // Last count value of the wait phase; unused when WAIT_CYC is 0.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              sub_q, sub_d;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              err_q, err_d;

    // Target-channel lookup for the captured request. A loop compare is used
    // instead of a direct index so an out-of-range channel simply misses.
    logic             ch_hit;
    logic [ACC_W-1:0] tgt_acc;

    always_comb begin
        ch_hit  = 1'b0;
        tgt_acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                ch_hit  = 1'b1;
                tgt_acc = acc_q[i];
            end
        end
    end

    // One extra bit on the intermediate: for add it is the carry, for
    // subtract it is the borrow (difference went negative).
    logic [ACC_W:0]   operand;
    logic [ACC_W:0]   raw_ext;
    logic             oflow;
    logic [ACC_W-1:0] result;

    assign operand = {{(ACC_W + 1 - DATA_W){1'b0}}, value_q};
    assign raw_ext = sub_q ? ({1'b0, tgt_acc} - operand)
                           : ({1'b0, tgt_acc} + operand);
    assign oflow   = raw_ext[ACC_W];

`ifdef CHAN_ACC_SATURATE_EN
    assign result = !oflow ? raw_ext[ACC_W-1:0] : (sub_q ? '0 : '1);
`else
    assign result = raw_ext[ACC_W-1:0];
`endif

    // NOTE: every variable written here gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        value_d = value_q;
        sub_d   = sub_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;

        if (clear) begin
            // Clear outranks acceptance and the ACCUM update alike.
            state_d = S_IDLE;
            cnt_d   = '0;
            ovf_d   = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        ch_d    = in_ch;
                        value_d = in_value;
                        sub_d   = in_sub;
                        cnt_d   = '0;
                        state_d = (WAIT_CYC > 0) ? S_WAIT : S_ACCUM;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_d = S_ACCUM;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_ACCUM: begin
                    state_d = S_IDLE;
                    err_d   = !ch_hit;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_q == CH_W'(i)) begin
                            acc_d[i] = result;
                            ovf_d[i] = ovf_q[i] | oflow;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register.
    // NOTE: the accumulator array is reset explicitly: it is architectural
    // state that must read back as zero after reset, not scratch storage.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            value_q <= '0;
            sub_q   <= 1'b0;
            acc_q   <= '{default: '0};
            ovf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            value_q <= value_d;
            sub_q   <= sub_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Read and LED ports; out-of-range selects read as zero.
    always_comb begin
        rd_data = '0;
        led     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_data = acc_q[i];
            end
            if (led_sel == CH_W'(i)) begin
                led = acc_q[i][LED_LSB +: 8];
            end
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign ovf      = ovf_q;
    assign err_ch   = err_q;

endmodule

// File: tb/tb_chan_accumulator.sv
// -----------------------------------------------------------------------------
// tb_chan_accumulator
//
// Directed bench for chan_accumulator. Instance u_dut uses default parameters
// (4 channels, WAIT_CYC=1); instance u_dut3 uses NUM_CH=3 so that an
// out-of-range channel can be presented. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_chan_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-parameter instance
    logic        in_valid, in_sub, clear;
    logic [1:0]  in_ch, rd_ch, led_sel;
    logic [31:0] in_value;
    logic        in_ready, err_ch, busy;
    logic [31:0] rd_data;
    logic [7:0]  led;
    logic [3:0]  ovf;

    // NUM_CH=3 instance
    logic        b_valid, b_sub, b_clear;
    logic [1:0]  b_ch, b_rd_ch, b_led_sel;
    logic [31:0] b_value;
    logic        b_ready, b_err, b_busy;
    logic [31:0] b_rd_data;
    logic [7:0]  b_led;
    logic [2:0]  b_ovf;

    chan_accumulator u_dut (
        .CLK(clk), .RST(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_value(in_value), .in_sub(in_sub), .clear(clear),
        .rd_ch(rd_ch), .rd_data(rd_data), .led_sel(led_sel), .led(led),
        .ovf(ovf), .err_ch(err_ch), .busy(busy)
    );

    chan_accumulator #(.NUM_CH(3)) u_dut3 (
        .CLK(clk), .RST(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_ch(b_ch),
        .in_value(b_value), .in_sub(b_sub), .clear(b_clear),
        .rd_ch(b_rd_ch), .rd_data(b_rd_data), .led_sel(b_led_sel), .led(b_led),
        .ovf(b_ovf), .err_ch(b_err), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Read one channel of u_dut through the combinational read port.
    task automatic a_read(input logic [1:0] ch, output logic [31:0] val);
        rd_ch = ch;
        #1;
        val = rd_data;
    endtask

    // Present one request to u_dut at a negedge, then wait (bounded) for
    // in_ready to return. n counts the negedges seen with in_ready low.
    task automatic a_issue(input logic [1:0] ch, input logic [31:0] val,
                           input logic sub, output int n);
        @(negedge clk);
        in_valid = 1'b1; in_ch = ch; in_value = val; in_sub = sub;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("a_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic b_issue(input logic [1:0] ch, input logic [31:0] val);
        int n;
        @(negedge clk);
        b_valid = 1'b1; b_ch = ch; b_value = val; b_sub = 1'b0;
        @(negedge clk);
        b_valid = 1'b0;
        n = 0;
        while (!b_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("b_ready_timeout", 32'(b_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          n;
        int          pulses;
        logic [31:0] exp_ch3, exp_ch0, exp_led0, exp_ch3b;

        in_valid = 0; in_sub = 0; clear = 0; in_ch = 0; rd_ch = 0; led_sel = 0; in_value = 0;
        b_valid = 0; b_sub = 0; b_clear = 0; b_ch = 0; b_rd_ch = 0; b_led_sel = 0; b_value = 0;
        rst = 1'b0;

        // ---------------- reset / defaults ----------------
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a_read(2'(i), v);
            check($sformatf("rst_rd_ch%0d", i), v, 32'h0);
        end
        check("rst_led", 32'(led), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_err", 32'(err_ch), 32'd0);

        // ---------------- cadence ----------------
        a_issue(2'd1, 32'h0001_0000, 1'b0, n);
        check("cad_busy_cycles", 32'(n), 32'd2);
        a_read(2'd1, v);
        check("cad_rd_ch1", v, 32'h0001_0000);
        led_sel = 2'd1;
        #1;
        check("cad_led_ch1", 32'(led), 32'h01);

        // ---------------- multi-channel add/sub ----------------
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        a_issue(2'd0, 32'd100, 1'b0, n);
        a_issue(2'd2, 32'd7,   1'b0, n);
        a_issue(2'd0, 32'd30,  1'b1, n);
        a_read(2'd0, v); check("mc_ch0", v, 32'd70);
        a_read(2'd1, v); check("mc_ch1", v, 32'd0);
        a_read(2'd2, v); check("mc_ch2", v, 32'd7);
        a_read(2'd3, v); check("mc_ch3", v, 32'd0);
        check("mc_ovf", 32'(ovf), 32'h0);

        // ---------------- overflow / underflow ----------------
`ifdef CHAN_ACC_SATURATE_EN
        exp_ch3  = 32'hFFFF_FFFF;
        exp_ch0  = 32'h0000_0000;
        exp_led0 = 32'h00;
        exp_ch3b = 32'hFFFF_FFFF;
`else
        exp_ch3  = 32'h0000_0010;
        exp_ch0  = 32'hFFFF_FFFC;
        exp_led0 = 32'hFF;
        exp_ch3b = 32'h0000_0011;
`endif
        a_issue(2'd3, 32'hFFFF_FFF0, 1'b0, n);
        a_read(2'd3, v); check("ov_ch3_pre", v, 32'hFFFF_FFF0);
        check("ov_ovf_pre", 32'(ovf), 32'h0);
        a_issue(2'd3, 32'h20, 1'b0, n);
        a_read(2'd3, v); check("ov_ch3", v, exp_ch3);
        check("ov_ovf3", 32'(ovf), 32'h8);
        a_issue(2'd0, 32'd65, 1'b1, n);
        a_read(2'd0, v); check("ov_ch0_5", v, 32'd5);
        a_issue(2'd0, 32'd9, 1'b1, n);
        a_read(2'd0, v); check("uf_ch0", v, exp_ch0);
        check("uf_ovf", 32'(ovf), 32'h9);
        led_sel = 2'd0;
        #1;
        check("uf_led_ch0", 32'(led), exp_led0);
        a_issue(2'd3, 32'd1, 1'b0, n);
        a_read(2'd3, v); check("ov_ch3_next", v, exp_ch3b);
        check("ovf_sticky", 32'(ovf), 32'h9);

        // ---------------- clear collides with ACCUM ----------------
        @(negedge clk);
        in_valid = 1'b1; in_ch = 2'd1; in_value = 32'd5; in_sub = 1'b0;
        @(negedge clk);                      // accepted; now in WAIT
        in_valid = 1'b0;
        @(negedge clk);                      // now in ACCUM
        check("clr_in_accum_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_ovf", 32'(ovf), 32'h0);
        for (int i = 0; i < 4; i++) begin
            a_read(2'(i), v);
            check($sformatf("clr_rd_ch%0d", i), v, 32'h0);
        end
        // Request presented together with clear is dropped.
        @(negedge clk);
        in_valid = 1'b1; in_ch = 2'd2; in_value = 32'd9; clear = 1'b1;
        #1;
        check("clr_ready_with_clear", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        check("drop_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        a_read(2'd2, v); check("drop_ch2", v, 32'h0);

        // ---------------- invalid channel (NUM_CH=3) ----------------
        b_issue(2'd2, 32'd4);
        @(negedge clk);
        b_valid = 1'b1; b_ch = 2'd3; b_value = 32'd9;
        @(negedge clk);                      // accepted at preceding edge T
        b_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (b_err) pulses++;
            if (k == 2) check("bad_err_at_T2", 32'(b_err), 32'd1);
            @(negedge clk);
        end
        check("bad_err_pulses", 32'(pulses), 32'd1);
        b_rd_ch = 2'd0; #1; check("bad_ch0", b_rd_data, 32'd0);
        b_rd_ch = 2'd1; #1; check("bad_ch1", b_rd_data, 32'd0);
        b_rd_ch = 2'd2; #1; check("bad_ch2", b_rd_data, 32'd4);
        b_rd_ch = 2'd3; #1; check("bad_rd_oob", b_rd_data, 32'd0);
        b_led_sel = 2'd3; #1; check("bad_led_oob", 32'(b_led), 32'd0);
        check("bad_ovf", 32'(b_ovf), 32'h0);

        // ---------------- async reset during WAIT ----------------
        @(negedge clk);
        b_valid = 1'b1; b_ch = 2'd0; b_value = 32'd3;
        @(negedge clk);                      // accepted; now in WAIT
        b_valid = 1'b0;
        check("ar_busy_before", 32'(b_busy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("ar_busy", 32'(b_busy), 32'd0);
        check("ar_ready", 32'(b_ready), 32'd1);
        b_rd_ch = 2'd2; #1;
        check("ar_ch2", b_rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        b_rd_ch = 2'd0; #1;
        check("ar_no_partial", b_rd_data, 32'd0);
        check("ar_err", 32'(b_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
